// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU control encodings: sequencer states and PC source select
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } seq_state_e;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_SEQ    = 2'd1,
    PC_TARGET = 2'd2,
    PC_STACK  = 2'd3
  } pc_src_e;

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - return-address stack with live occupancy count and full/empty flags
module ras_stack #(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ADDR_W-1:0]          push_data,
  output logic [ADDR_W-1:0]          top,
  output logic [$clog2(RAS_DEPTH):0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int IW = $clog2(RAS_DEPTH);
  localparam int CW = IW + 1;

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [IW-1:0]     top_idx;

  assign full    = (count == CW'(RAS_DEPTH));
  assign empty   = (count == '0);
  assign top_idx = count[IW-1:0] - IW'(1);
  assign top     = mem[top_idx];

  // Entries are never reset; count=0 keeps stale contents unreachable.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[count[IW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CW'(1);
    end else if (pop && !empty) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer with RUN/HALTED/FAULT control and return-address stack
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                PC_STEP   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cont,
  input  logic                       halt,
  input  logic                       stall,
  input  logic                       jump,
  input  logic                       call,
  input  logic                       ret,
  input  logic [ADDR_W-1:0]          target,
  output logic [ADDR_W-1:0]          pc,
  output logic                       run_en,
  output logic                       halted,
  output logic                       fault,
  output logic [$clog2(RAS_DEPTH):0] ras_count
);

  seq_state_e        state, state_next;
  pc_src_e           pc_src;
  logic [ADDR_W-1:0] pc_seq, pc_next, ras_top;
  logic              push, pop, ras_full, ras_empty;

  assign pc_seq = pc + ADDR_W'(PC_STEP);
  assign run_en = (state == ST_RUN) && !stall;

  ras_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_seq),
    .top       (ras_top),
    .count     (ras_count),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_RUN;
      pc     <= RESET_PC;
      halted <= 1'b0;
      fault  <= 1'b0;
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      halted <= (state_next == ST_HALTED);
      fault  <= (state_next == ST_FAULT);
    end
  end

  always_comb begin
    state_next = state;
    pc_src     = PC_HOLD;
    push       = 1'b0;
    pop        = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (stall) begin
          pc_src = PC_HOLD;
        end else if (halt) begin
          state_next = ST_HALTED;
        end else if (ret) begin
          // Underflow faults with pc held so cont re-executes the ret.
          if (ras_empty) begin
            state_next = ST_FAULT;
          end else begin
            pop    = 1'b1;
            pc_src = PC_STACK;
          end
        end else if (call) begin
          if (ras_full) begin
            state_next = ST_FAULT;
          end else begin
            push   = 1'b1;
            pc_src = PC_TARGET;
          end
        end else if (jump) begin
          pc_src = PC_TARGET;
        end else begin
          pc_src = PC_SEQ;
        end
      end
      ST_HALTED: begin
        if (cont) begin
          state_next = ST_RUN;
          pc_src     = PC_SEQ;
        end
      end
      ST_FAULT: begin
        if (cont) begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_comb begin
    pc_next = pc;
    case (pc_src)
      PC_SEQ:    pc_next = pc_seq;
      PC_TARGET: pc_next = target;
      PC_STACK:  pc_next = ras_top;
      default:   pc_next = pc;
    endcase
  end

endmodule
